// File: rtl/frame_capture_pkg.sv
// Shared types and default geometry for the frame capture block.
// The state encoding and address-width helper are used by the top and the RAM.
package frame_capture_pkg;

   localparam int H_ACTIVE_DEF = 256;
   localparam int V_ACTIVE_DEF = 240;
   localparam int CHAN_W_DEF   = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_e;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/frame_capture_if.sv
// Readout bus of the frame capture block: strobe/address from the reader,
// registered pixel and qualifier back from the buffer.
interface frame_capture_if #(
   parameter int ADDR_W = 16,
   parameter int PIX_W  = 6
);

   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  rd_data;
   logic              rd_valid;

   modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
   modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);

endinterface

// File: rtl/frame_capture_ram.sv
// Simple dual-port frame store with one write port and a registered read port.
// The buffer index is the address MSB, so each bank spans a power-of-two range.
module frame_capture_ram
   import frame_capture_pkg::*;
#(
   parameter int NUM_BUFS = 2,
   parameter int ADDR_W   = 16,
   parameter int PIX_W    = 6
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W:0]   wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W:0]   rd_addr,
   output logic [PIX_W-1:0]  rd_data
);

   logic [PIX_W-1:0] rd_data_q;

   generate
      if (NUM_BUFS == 2) begin : g_dual
         logic [PIX_W-1:0] mem [0:(2**(ADDR_W+1))-1];

         // Write port and read-before-write registered read port.
         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
               rd_data_q <= mem[rd_addr];
            end
         end
      end else begin : g_single
         logic [PIX_W-1:0] mem [0:(2**ADDR_W)-1];
         logic             unused_bank_s;

         // With a single buffer the bank bit is always zero.
         assign unused_bank_s = wr_addr[ADDR_W] ^ rd_addr[ADDR_W];

         // Write port and read-before-write registered read port.
         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[wr_addr[ADDR_W-1:0]] <= wr_data;
            end
            if (rd_en) begin
               rd_data_q <= mem[rd_addr[ADDR_W-1:0]];
            end
         end
      end
   endgenerate

   assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_capture.sv
// Captures one visible frame of a PPU pixel stream into a (double) buffer,
// mirrors the stream onto registered VGA outputs and serves buffer readout.
module frame_capture
   import frame_capture_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int CHAN_W   = CHAN_W_DEF,
   parameter int NUM_BUFS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic [8:0]            cycle,
   input  logic [8:0]            scanline,
   input  logic [3*CHAN_W-1:0]   color,
   input  logic                  capture_req,
   input  logic                  continuous,
   input  logic                  abort,
   output logic                  busy,
   output logic                  frame_done,
   output logic [15:0]           frame_count,
   frame_capture_if.slave        rd,
   output logic [CHAN_W-1:0]     vga_r,
   output logic [CHAN_W-1:0]     vga_g,
   output logic [CHAN_W-1:0]     vga_b,
   output logic [8:0]            vga_cycle,
   output logic [8:0]            vga_scanline
);

   localparam int          PIX_W  = 3 * CHAN_W;
   localparam int          ADDR_W = addr_width(H_ACTIVE * V_ACTIVE);
   localparam logic [31:0] H_U    = 32'(H_ACTIVE);
   localparam logic [31:0] V_U    = 32'(V_ACTIVE);

   cap_state_e        state_q, state_d;
   logic [15:0]       frame_count_q, frame_count_d;
   logic              wr_buf_q, wr_buf_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              rd_valid_q, rd_valid_d;
   logic [CHAN_W-1:0] vga_r_q, vga_r_d;
   logic [CHAN_W-1:0] vga_g_q, vga_g_d;
   logic [CHAN_W-1:0] vga_b_q, vga_b_d;
   logic [8:0]        vga_cycle_q, vga_cycle_d;
   logic [8:0]        vga_scanline_q, vga_scanline_d;

   logic              in_view_s;
   logic              frame_start_s;
   logic              last_pix_s;
   logic              wr_en_s;
   logic              disp_buf_s;
   logic [ADDR_W:0]   wr_addr_s;
   logic [ADDR_W:0]   rd_addr_s;
   logic [PIX_W-1:0]  ram_rd_data_s;

   // Dot classification and buffer addressing; display bank is the one not written.
   always_comb begin
      in_view_s     = ce && (32'(cycle) < H_U) && (32'(scanline) < V_U);
      frame_start_s = ce && (cycle == 9'd0) && (scanline == 9'd0);
      last_pix_s    = (32'(cycle) == (H_U - 32'd1)) && (32'(scanline) == (V_U - 32'd1));
      disp_buf_s    = (NUM_BUFS == 2) ? ~wr_buf_q : 1'b0;
      wr_addr_s     = {wr_buf_q, ADDR_W'(32'(scanline) * H_U + 32'(cycle))};
      rd_addr_s     = {disp_buf_s, rd.rd_addr};
   end

   // Capture FSM: abort wins in ARMED/CAPTURE, DONE always lasts one clock.
   always_comb begin
      state_d       = state_q;
      wr_en_s       = 1'b0;
      frame_count_d = frame_count_q;
      wr_buf_d      = wr_buf_q;
      case (state_q)
         IDLE: begin
            if (capture_req) begin
               state_d = ARMED;
            end else begin
               state_d = IDLE;
            end
         end
         ARMED: begin
            if (abort) begin
               state_d = IDLE;
            end else if (frame_start_s) begin
               wr_en_s = 1'b1;
               state_d = last_pix_s ? DONE : CAPTURE;
            end else begin
               state_d = ARMED;
            end
         end
         CAPTURE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (in_view_s) begin
               wr_en_s = 1'b1;
               state_d = last_pix_s ? DONE : CAPTURE;
            end else begin
               state_d = CAPTURE;
            end
         end
         DONE: begin
            frame_count_d = frame_count_q + 16'd1;
            if (NUM_BUFS == 2) begin
               wr_buf_d = ~wr_buf_q;
            end else begin
               wr_buf_d = wr_buf_q;
            end
            state_d = (continuous && !abort) ? ARMED : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d       = (state_d == ARMED) || (state_d == CAPTURE);
      frame_done_d = (state_d == DONE);
      rd_valid_d   = rd.rd_en;
   end

   // VGA mirror follows the stream on enabled dots and holds otherwise.
   always_comb begin
      vga_r_d        = vga_r_q;
      vga_g_d        = vga_g_q;
      vga_b_d        = vga_b_q;
      vga_cycle_d    = vga_cycle_q;
      vga_scanline_d = vga_scanline_q;
      if (ce) begin
         vga_r_d        = color[3*CHAN_W-1:2*CHAN_W];
         vga_g_d        = color[2*CHAN_W-1:CHAN_W];
         vga_b_d        = color[CHAN_W-1:0];
         vga_cycle_d    = cycle;
         vga_scanline_d = scanline;
      end else begin
         vga_r_d        = vga_r_q;
         vga_g_d        = vga_g_q;
         vga_b_d        = vga_b_q;
         vga_cycle_d    = vga_cycle_q;
         vga_scanline_d = vga_scanline_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         frame_count_q  <= 16'd0;
         wr_buf_q       <= 1'b0;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         rd_valid_q     <= 1'b0;
         vga_r_q        <= '0;
         vga_g_q        <= '0;
         vga_b_q        <= '0;
         vga_cycle_q    <= 9'd0;
         vga_scanline_q <= 9'd0;
      end else begin
         state_q        <= state_d;
         frame_count_q  <= frame_count_d;
         wr_buf_q       <= wr_buf_d;
         busy_q         <= busy_d;
         frame_done_q   <= frame_done_d;
         rd_valid_q     <= rd_valid_d;
         vga_r_q        <= vga_r_d;
         vga_g_q        <= vga_g_d;
         vga_b_q        <= vga_b_d;
         vga_cycle_q    <= vga_cycle_d;
         vga_scanline_q <= vga_scanline_d;
      end
   end

   frame_capture_ram #(
      .NUM_BUFS (NUM_BUFS),
      .ADDR_W   (ADDR_W),
      .PIX_W    (PIX_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .wr_addr (wr_addr_s),
      .wr_data (color),
      .rd_en   (rd.rd_en),
      .rd_addr (rd_addr_s),
      .rd_data (ram_rd_data_s)
   );

   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign frame_count  = frame_count_q;
   assign rd.rd_data   = ram_rd_data_s;
   assign rd.rd_valid  = rd_valid_q;
   assign vga_r        = vga_r_q;
   assign vga_g        = vga_g_q;
   assign vga_b        = vga_b_q;
   assign vga_cycle    = vga_cycle_q;
   assign vga_scanline = vga_scanline_q;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture on a 4x3 double-buffered geometry.
module tb_frame_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic [8:0]  cycle;
   logic [8:0]  scanline;
   logic [5:0]  color;
   logic        capture_req;
   logic        continuous;
   logic        abort;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_count;
   logic [1:0]  vga_r, vga_g, vga_b;
   logic [8:0]  vga_cycle, vga_scanline;

   int checks   = 0;
   int failures = 0;
   int fd_seen  = 0;

   frame_capture_if #(.ADDR_W(4), .PIX_W(6)) rd_if ();

   frame_capture #(
      .H_ACTIVE (4),
      .V_ACTIVE (3),
      .CHAN_W   (2),
      .NUM_BUFS (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ce           (ce),
      .cycle        (cycle),
      .scanline     (scanline),
      .color        (color),
      .capture_req  (capture_req),
      .continuous   (continuous),
      .abort        (abort),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_count  (frame_count),
      .rd           (rd_if),
      .vga_r        (vga_r),
      .vga_g        (vga_g),
      .vga_b        (vga_b),
      .vga_cycle    (vga_cycle),
      .vga_scanline (vga_scanline)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dot(input logic c, input int sl, input int cy, input logic [5:0] col);
      ce       = c;
      scanline = 9'(sl);
      cycle    = 9'(cy);
      color    = col;
      tick();
   endtask

   task automatic arm();
      ce          = 1'b0;
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
      check_eq("busy_armed", 32'(busy), 32'd1);
   endtask

   // mode < 0: pixel colour = its linear index; otherwise constant mode.
   task automatic scan_frame(input int mode, input logic rd_chk, input logic [5:0] rd_exp);
      logic [5:0] col;
      fd_seen = 0;
      for (int sl = 0; sl < 4; sl++) begin
         for (int cy = 0; cy < 6; cy++) begin
            if (sl < 3 && cy < 4) col = (mode < 0) ? 6'(sl * 4 + cy) : 6'(mode);
            else                  col = 6'h3F;
            rd_if.rd_en   = 1'b1;
            rd_if.rd_addr = 4'((sl * 4 + cy) % 12);
            dot(1'b1, sl, cy, col);
            if (frame_done) fd_seen++;
            check_eq("vga_follow", 32'({vga_scanline, vga_cycle, vga_r, vga_g, vga_b}),
                     32'({9'(sl), 9'(cy), col}));
            check_eq("rd_valid", 32'(rd_if.rd_valid), 32'd1);
            if (sl == 2 && cy == 3) check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
            if (rd_chk && (sl < 2 || (sl == 2 && cy <= 4)))
               check_eq("display_during_capture", 32'(rd_if.rd_data), 32'(rd_exp));
            if (sl == 1 && cy == 1) begin
               rd_if.rd_en = 1'b0;
               for (int k = 0; k < 5; k++) begin
                  dot(1'b0, 0, 1, 6'h3F);
                  check_eq("vga_hold_ce0", 32'({vga_scanline, vga_cycle, vga_r, vga_g, vga_b}),
                           32'({9'd1, 9'd1, col}));
               end
            end
            if (sl == 1 && cy == 5) begin
               rd_if.rd_en = 1'b0;
               dot(1'b1, 0, 4, 6'h3F);
               dot(1'b1, 0, 7, 6'h3F);
               dot(1'b1, 4, 0, 6'h3F);
            end
         end
      end
      rd_if.rd_en = 1'b0;
      ce          = 1'b0;
      check_eq("frame_done_once", 32'(fd_seen), 32'd1);
   endtask

   task automatic read_one(input int addr, input logic [5:0] exp);
      rd_if.rd_en   = 1'b1;
      rd_if.rd_addr = 4'(addr);
      tick();
      check_eq("rd_valid_read", 32'(rd_if.rd_valid), 32'd1);
      check_eq("rd_data", 32'(rd_if.rd_data), 32'(exp));
   endtask

   // Back-to-back reads of the whole visible frame, then check the qualifier drops.
   task automatic read_all(input int mode);
      for (int a = 0; a < 12; a++) begin
         read_one(a, (mode < 0) ? 6'(a) : 6'(mode));
      end
      rd_if.rd_en = 1'b0;
      tick();
      check_eq("rd_valid_drop", 32'(rd_if.rd_valid), 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      ce            = 1'b0;
      cycle         = 9'd0;
      scanline      = 9'd0;
      color         = 6'h00;
      capture_req   = 1'b0;
      continuous    = 1'b0;
      abort         = 1'b0;
      rd_if.rd_en   = 1'b0;
      rd_if.rd_addr = 4'd0;
      repeat (3) tick();
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_frame_done", 32'(frame_done), 32'd0);
      check_eq("reset_rd_valid", 32'(rd_if.rd_valid), 32'd0);
      check_eq("reset_frame_count", 32'(frame_count), 32'd0);
      check_eq("reset_vga", 32'({vga_scanline, vga_cycle, vga_r, vga_g, vga_b}), 32'd0);
      reset = 1'b0;
      tick();

      // Single capture of an index pattern, with blanking and ce gating inside.
      arm();
      scan_frame(-1, 1'b0, 6'h00);
      check_eq("single_busy_idle", 32'(busy), 32'd0);
      check_eq("single_count", 32'(frame_count), 32'd1);
      read_all(-1);

      // Continuous double buffering: frame of 0x01 then frame of 0x02.
      arm();
      continuous = 1'b1;
      scan_frame(1, 1'b0, 6'h00);
      check_eq("cont_busy_rearmed", 32'(busy), 32'd1);
      check_eq("cont_count1", 32'(frame_count), 32'd2);
      continuous = 1'b0;
      scan_frame(2, 1'b1, 6'h01);
      check_eq("cont_count2", 32'(frame_count), 32'd3);
      check_eq("cont_busy_idle", 32'(busy), 32'd0);
      read_all(2);

      // Abort on the first dot of scanline 1.
      arm();
      for (int cy = 0; cy < 4; cy++) dot(1'b1, 0, cy, 6'h3F);
      check_eq("abort_busy_before", 32'(busy), 32'd1);
      abort = 1'b1;
      dot(1'b1, 1, 0, 6'h3F);
      abort = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      fd_seen = 0;
      for (int cy = 1; cy < 4; cy++) begin
         dot(1'b1, 1, cy, 6'h3F);
         if (frame_done) fd_seen++;
      end
      check_eq("abort_no_done", 32'(fd_seen), 32'd0);
      check_eq("abort_count", 32'(frame_count), 32'd3);
      read_all(2);

      // Reset while capturing scanline 2.
      arm();
      rd_if.rd_en   = 1'b1;
      rd_if.rd_addr = 4'd0;
      for (int sl = 0; sl < 2; sl++)
         for (int cy = 0; cy < 4; cy++) dot(1'b1, sl, cy, 6'h15);
      dot(1'b1, 2, 0, 6'h15);
      check_eq("pre_reset_rd_valid", 32'(rd_if.rd_valid), 32'd1);
      check_eq("pre_reset_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_frame_done", 32'(frame_done), 32'd0);
      check_eq("midrst_rd_valid", 32'(rd_if.rd_valid), 32'd0);
      check_eq("midrst_count", 32'(frame_count), 32'd0);
      check_eq("midrst_vga", 32'({vga_scanline, vga_cycle, vga_r, vga_g, vga_b}), 32'd0);
      rd_if.rd_en = 1'b0;
      ce          = 1'b0;
      tick();
      reset   = 1'b0;
      fd_seen = 0;
      for (int cy = 1; cy < 4; cy++) begin
         dot(1'b1, 2, cy, 6'h15);
         if (frame_done) fd_seen++;
      end
      ce = 1'b0;
      check_eq("postrst_no_done", 32'(fd_seen), 32'd0);
      check_eq("postrst_busy", 32'(busy), 32'd0);
      check_eq("postrst_count", 32'(frame_count), 32'd0);
      read_one(8, 6'h15);
      read_one(9, 6'h01);
      read_one(11, 6'h01);
      rd_if.rd_en = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
